// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the two-master SPI RAM arbiter.
package spi_ram_arb_pkg;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; last_grant moves only when the sequencer commits a grant.
module rr_arb2
  import spi_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt_valid,
  output logic gnt_id,
  output logic last_grant
);

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) gnt_id = ~last_grant;
    else if (req1)    gnt_id = M_AUX;
    else              gnt_id = M_CPU;
  end

  // Reset to AUX so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)      last_grant <= M_AUX;
    else if (update) last_grant <= gnt_id;
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI RAM controller between CPU (master 0) and an auxiliary requester (master 1).
// Optional busy-wait timeout with error flag: define ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | pick a winner, latch its addr/wdata/we
// ISSUE  | one-cycle rd or wr strobe to the slave
// SETTLE | ignore busy while the slave raises it
// WAIT   | hold until the relevant busy drops (or times out)
// DONE   | ack (and err on timeout) to the granted master
module spi_ram_arbiter
  import spi_ram_arb_pkg::*;
#(
  parameter int AW      = ARB_AW,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_rd,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rbusy,
  input  logic          s_wbusy,
  output logic          grant,
  output logic          busy
);

  arb_state_e state_q, state_d;
  logic       arb_update, finish, tmo_hit, tmo_reached;
  logic       gnt_valid, gnt_id, last_grant;
  logic       we_q, sel_we, busy_sel;

  rr_arb2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req0      (m0_req),
    .req1      (m1_req),
    .update    (arb_update),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .last_grant(last_grant)
  );

  assign sel_we   = gnt_id ? m1_we : m0_we;
  assign busy_sel = we_q ? s_wbusy : s_rbusy;
  assign grant    = last_grant;
  assign busy     = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt;

  // Cleared outside WAIT, so it counts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!reset)                      tmo_cnt <= '0;
    else if (state_q != WAIT)        tmo_cnt <= '0;
    else if (tmo_cnt != {TW{1'b1}})  tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_reached = (tmo_cnt == TW'(TIMEOUT));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT < (1 << TW));
  assign tmo_reached    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    arb_update = 1'b0;
    finish     = 1'b0;
    tmo_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = ISSUE;
          arb_update = 1'b1;
        end
      end
      ISSUE:  state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (!busy_sel) begin
          state_d = DONE;
          finish  = 1'b1;
        end else if (tmo_reached) begin
          state_d = DONE;
          finish  = 1'b1;
          tmo_hit = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and acks are registered so they line up with ISSUE and DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s_rd     <= 1'b0;
      s_wr     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      we_q     <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      s_rd   <= 1'b0;
      s_wr   <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      if (arb_update) begin
        we_q    <= sel_we;
        s_addr  <= gnt_id ? m1_addr  : m0_addr;
        s_wdata <= gnt_id ? m1_wdata : m0_wdata;
        s_rd    <= ~sel_we;
        s_wr    <= sel_we;
      end
      if (finish) begin
        if (last_grant == M_AUX) begin
          m1_ack <= 1'b1;
          m1_err <= tmo_hit;
          if (!we_q && !tmo_hit) m1_rdata <= s_rdata;
        end else begin
          m0_ack <= 1'b1;
          m0_err <= tmo_hit;
          if (!we_q && !tmo_hit) m0_rdata <= s_rdata;
        end
      end
    end
  end

endmodule
